// File: rtl/s27_bist_ctrl_if.sv
// Control handshake between the s27 BIST controller and whatever sequences it.
// The slave side is the controller; the master side issues start/abort and watches the results.
interface s27_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] signature;
    logic [7:0] pat_idx;

    modport master (
        output start, abort,
        input  busy, done, pass, signature, pat_idx
    );

    modport slave (
        input  start, abort,
        output busy, done, pass, signature, pat_idx
    );
endinterface

// File: rtl/s27_bist_ctrl.sv
// BIST controller for the s27 core: an LFSR drives G0-G7 (G4 unused) and a MISR
// compacts G17/n12/n17/n22, then the final signature is compared to a golden value.
module s27_bist_ctrl #(
    parameter int unsigned PAT_COUNT  = 64,
    parameter logic [6:0]  LFSR_SEED  = 7'h01,
    parameter logic [3:0]  MISR_SEED  = 4'h0,
    parameter logic [3:0]  GOLDEN_SIG = 4'h0
) (
    input  logic                 CK,
    input  logic                 RST,
    s27_bist_ctrl_if.slave       ctrl,
    input  logic                 G17,
    input  logic                 n12,
    input  logic                 n17,
    input  logic                 n22,
    output logic                 G0,
    output logic                 G1,
    output logic                 G2,
    output logic                 G3,
    output logic                 G5,
    output logic                 G6,
    output logic                 G7
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        CAPTURE,
        COMPARE,
        DONE
    } state_t;

    localparam logic [7:0] PAT_LAST = 8'(PAT_COUNT);

    state_t     state;
    logic [6:0] lfsr;
    logic [6:0] pattern;
    logic [3:0] misr;
    logic [7:0] pat_idx;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    logic [3:0] resp;
    logic [6:0] lfsr_step;
    logic [3:0] misr_step;
    logic [7:0] idx_step;
    logic       in_run;

    assign resp      = {G17, n12, n17, n22};
    assign lfsr_step = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    assign misr_step = {misr[2:0], misr[3] ^ misr[2]} ^ resp;
    assign idx_step  = pat_idx + 8'd1;
    assign in_run    = (state == APPLY) || (state == CAPTURE) || (state == COMPARE);

    // The pattern register is loaded with the value the pins must show in the
    // next state, so pins change on the same edge as the state does.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            lfsr    <= LFSR_SEED;
            misr    <= MISR_SEED;
            pat_idx <= 8'd0;
            pattern <= 7'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (ctrl.abort && in_run) begin
            // misr and pat_idx are left as they were so an aborted run can be inspected
            state   <= IDLE;
            pattern <= 7'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ctrl.start && !ctrl.abort) begin
                        state   <= APPLY;
                        lfsr    <= LFSR_SEED;
                        misr    <= MISR_SEED;
                        pat_idx <= 8'd0;
                        pattern <= LFSR_SEED;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                APPLY: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    misr    <= misr_step;
                    lfsr    <= lfsr_step;
                    pat_idx <= idx_step;
                    if (idx_step == PAT_LAST) begin
                        state   <= COMPARE;
                        pattern <= 7'd0;
                    end else begin
                        state   <= APPLY;
                        pattern <= lfsr_step;
                    end
                end
                COMPARE: begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (misr == GOLDEN_SIG);
                end
                default: begin
                    state   <= IDLE;
                    pattern <= 7'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {G7, G6, G5, G3, G2, G1, G0} = pattern;

    assign ctrl.busy      = busy_q;
    assign ctrl.done      = done_q;
    assign ctrl.pass      = pass_q;
    assign ctrl.signature = misr;
    assign ctrl.pat_idx   = pat_idx;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Self-checking bench for s27_bist_ctrl: four instances with different pattern counts,
// random responses scored against a behavioural LFSR/MISR model.
module tb_s27_bist_ctrl;

    logic       CK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] resp = 4'h0;

    wire [6:0] pins8;
    wire [6:0] pins64;
    wire [6:0] pins1;
    wire [6:0] pins2;

    int checks = 0;
    int errors = 0;

    logic [6:0] spec_seq [8];

    s27_bist_ctrl_if if8 ();
    s27_bist_ctrl_if if64 ();
    s27_bist_ctrl_if if1 ();
    s27_bist_ctrl_if if2 ();

    always #5 CK = ~CK;

    s27_bist_ctrl #(.PAT_COUNT(8), .LFSR_SEED(7'h01), .MISR_SEED(4'h0), .GOLDEN_SIG(4'h0)) dut8 (
        .CK(CK), .RST(RST), .ctrl(if8),
        .G17(resp[3]), .n12(resp[2]), .n17(resp[1]), .n22(resp[0]),
        .G0(pins8[0]), .G1(pins8[1]), .G2(pins8[2]), .G3(pins8[3]),
        .G5(pins8[4]), .G6(pins8[5]), .G7(pins8[6])
    );

    s27_bist_ctrl #(.PAT_COUNT(64), .LFSR_SEED(7'h01), .MISR_SEED(4'h0), .GOLDEN_SIG(4'h0)) dut64 (
        .CK(CK), .RST(RST), .ctrl(if64),
        .G17(resp[3]), .n12(resp[2]), .n17(resp[1]), .n22(resp[0]),
        .G0(pins64[0]), .G1(pins64[1]), .G2(pins64[2]), .G3(pins64[3]),
        .G5(pins64[4]), .G6(pins64[5]), .G7(pins64[6])
    );

    s27_bist_ctrl #(.PAT_COUNT(1), .LFSR_SEED(7'h01), .MISR_SEED(4'h0), .GOLDEN_SIG(4'h0)) dut1 (
        .CK(CK), .RST(RST), .ctrl(if1),
        .G17(resp[3]), .n12(resp[2]), .n17(resp[1]), .n22(resp[0]),
        .G0(pins1[0]), .G1(pins1[1]), .G2(pins1[2]), .G3(pins1[3]),
        .G5(pins1[4]), .G6(pins1[5]), .G7(pins1[6])
    );

    s27_bist_ctrl #(.PAT_COUNT(2), .LFSR_SEED(7'h01), .MISR_SEED(4'h0), .GOLDEN_SIG(4'h0)) dut2 (
        .CK(CK), .RST(RST), .ctrl(if2),
        .G17(resp[3]), .n12(resp[2]), .n17(resp[1]), .n22(resp[0]),
        .G0(pins2[0]), .G1(pins2[1]), .G2(pins2[2]), .G3(pins2[3]),
        .G5(pins2[4]), .G6(pins2[5]), .G7(pins2[6])
    );

    // Reference model: the n-th pattern of a run and one MISR compaction step.
    function automatic logic [6:0] model_pattern(int n);
        logic [6:0] v;
        v = 7'h01;
        for (int i = 0; i < n; i++) v = {v[5:0], v[6] ^ v[5]};
        return v;
    endfunction

    function automatic logic [3:0] model_misr(logic [3:0] s, logic [3:0] r);
        return {s[2:0], s[3] ^ s[2]} ^ r;
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Full 8-pattern run on dut8 with random responses every cycle; only the
    // values present during CAPTURE (odd cycles after start) feed the model.
    task automatic run_d8(output logic [3:0] exp_sig, output int busy_cyc,
                          output logic [6:0] first_pat, output bit timed_out);
        exp_sig   = 4'h0;
        busy_cyc  = 0;
        timed_out = 1'b1;
        if8.start = 1'b1;
        resp      = 4'($urandom);
        tick();
        if8.start = 1'b0;
        first_pat = pins8;
        for (int m = 0; m < 100; m++) begin
            if (!if8.busy) begin
                timed_out = 1'b0;
                break;
            end
            busy_cyc++;
            resp = 4'($urandom);
            if ((m % 2 == 1) && (m < 16)) exp_sig = model_misr(exp_sig, resp);
            tick();
        end
    endtask

    task automatic test_reset();
        #2 RST = 1'b1;
        #1;
        checks++; if (pins8 !== 7'h00) begin errors++; $display("[TB] FAIL reset_pins got %0h expected 0", pins8); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b expected 0", if8.busy); end
        checks++; if (if8.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b expected 0", if8.done); end
        checks++; if (if8.pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass got %0b expected 0", if8.pass); end
        checks++; if (if8.signature !== 4'h0) begin errors++; $display("[TB] FAIL reset_sig got %0h expected 0", if8.signature); end
        checks++; if (if8.pat_idx !== 8'd0) begin errors++; $display("[TB] FAIL reset_idx got %0d expected 0", if8.pat_idx); end
        #1 RST = 1'b0;
    endtask

    task automatic test_lfsr_sequence();
        int busy_cyc;
        resp      = 4'h0;
        busy_cyc  = 0;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        for (int m = 0; m < 40; m++) begin
            if (!if8.busy) break;
            busy_cyc++;
            if (m < 16) begin
                checks++;
                if (pins8 !== spec_seq[m / 2]) begin
                    errors++;
                    $display("[TB] FAIL lfsr_pattern cycle %0d got %0h expected %0h", m, pins8, spec_seq[m / 2]);
                end
            end
            tick();
        end
        checks++; if (busy_cyc != 17) begin errors++; $display("[TB] FAIL lfsr_busy_len got %0d expected 17", busy_cyc); end
        checks++; if (if8.done !== 1'b1) begin errors++; $display("[TB] FAIL lfsr_done got %0b expected 1", if8.done); end
        checks++; if (if8.pass !== 1'b1) begin errors++; $display("[TB] FAIL lfsr_pass got %0b expected 1", if8.pass); end
        checks++; if (pins8 !== 7'h00) begin errors++; $display("[TB] FAIL lfsr_pins_done got %0h expected 0", pins8); end
        checks++; if (if8.pat_idx !== 8'd8) begin errors++; $display("[TB] FAIL lfsr_idx got %0d expected 8", if8.pat_idx); end
    endtask

    task automatic test_golden();
        int busy_cyc;
        resp       = 4'h0;
        busy_cyc   = 0;
        if64.start = 1'b1;
        tick();
        if64.start = 1'b0;
        for (int m = 0; m < 300; m++) begin
            if (!if64.busy) break;
            busy_cyc++;
            tick();
        end
        checks++; if (busy_cyc != 129) begin errors++; $display("[TB] FAIL golden_busy_len got %0d expected 129", busy_cyc); end
        checks++; if (if64.signature !== 4'h0) begin errors++; $display("[TB] FAIL golden_sig got %0h expected 0", if64.signature); end
        checks++; if (if64.pass !== 1'b1) begin errors++; $display("[TB] FAIL golden_pass got %0b expected 1", if64.pass); end
        checks++; if (if64.done !== 1'b1) begin errors++; $display("[TB] FAIL golden_done got %0b expected 1", if64.done); end
        checks++; if (if64.pat_idx !== 8'd64) begin errors++; $display("[TB] FAIL golden_idx got %0d expected 64", if64.pat_idx); end
        checks++; if (pins64 !== 7'h00) begin errors++; $display("[TB] FAIL golden_pins got %0h expected 0", pins64); end
    endtask

    task automatic test_mismatch();
        resp      = 4'h0;
        if1.start = 1'b1;
        if2.start = 1'b1;
        tick();
        if1.start = 1'b0;
        if2.start = 1'b0;
        for (int m = 0; m < 6; m++) begin
            resp = ((m == 1) || (m == 3)) ? 4'b0001 : 4'b0000;
            tick();
            if (m == 2) begin
                checks++; if (if1.signature !== 4'h1) begin errors++; $display("[TB] FAIL mismatch1_sig got %0h expected 1", if1.signature); end
                checks++; if (if1.pass !== 1'b0) begin errors++; $display("[TB] FAIL mismatch1_pass got %0b expected 0", if1.pass); end
                checks++; if (if1.done !== 1'b1) begin errors++; $display("[TB] FAIL mismatch1_done got %0b expected 1", if1.done); end
                checks++; if (pins1 !== 7'h00) begin errors++; $display("[TB] FAIL mismatch1_pins got %0h expected 0", pins1); end
            end
            if (m == 4) begin
                checks++; if (if2.signature !== 4'h3) begin errors++; $display("[TB] FAIL mismatch2_sig got %0h expected 3", if2.signature); end
                checks++; if (if2.pass !== 1'b0) begin errors++; $display("[TB] FAIL mismatch2_pass got %0b expected 0", if2.pass); end
                checks++; if (if2.done !== 1'b1) begin errors++; $display("[TB] FAIL mismatch2_done got %0b expected 1", if2.done); end
                checks++; if (pins2 !== 7'h00) begin errors++; $display("[TB] FAIL mismatch2_pins got %0h expected 0", pins2); end
            end
        end
    endtask

    task automatic test_abort_restart();
        logic [3:0] exp_sig;
        logic [6:0] first_pat;
        int         busy_cyc;
        bit         timed_out;
        exp_sig   = 4'h0;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        for (int m = 0; m < 8; m++) begin
            resp = 4'($urandom);
            if (m % 2 == 1) exp_sig = model_misr(exp_sig, resp);
            tick();
        end
        if8.abort = 1'b1;
        resp      = 4'($urandom);
        tick();
        if8.abort = 1'b0;
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %0b expected 0", if8.busy); end
        checks++; if (if8.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %0b expected 0", if8.done); end
        checks++; if (if8.pass !== 1'b0) begin errors++; $display("[TB] FAIL abort_pass got %0b expected 0", if8.pass); end
        checks++; if (if8.pat_idx !== 8'd4) begin errors++; $display("[TB] FAIL abort_idx got %0d expected 4", if8.pat_idx); end
        checks++; if (if8.signature !== exp_sig) begin errors++; $display("[TB] FAIL abort_sig got %0h expected %0h", if8.signature, exp_sig); end
        checks++; if (pins8 !== 7'h00) begin errors++; $display("[TB] FAIL abort_pins got %0h expected 0", pins8); end

        if8.start = 1'b1;
        if8.abort = 1'b1;
        tick();
        if8.start = 1'b0;
        if8.abort = 1'b0;
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("[TB] FAIL start_abort_busy got %0b expected 0", if8.busy); end
        checks++; if (if8.pat_idx !== 8'd4) begin errors++; $display("[TB] FAIL start_abort_idx got %0d expected 4", if8.pat_idx); end

        run_d8(exp_sig, busy_cyc, first_pat, timed_out);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL restart_timeout got busy after %0d cycles expected idle", busy_cyc); end
        checks++; if (first_pat !== 7'h01) begin errors++; $display("[TB] FAIL restart_first_pat got %0h expected 01", first_pat); end
        checks++; if (busy_cyc != 17) begin errors++; $display("[TB] FAIL restart_busy_len got %0d expected 17", busy_cyc); end
        checks++; if (if8.signature !== exp_sig) begin errors++; $display("[TB] FAIL restart_sig got %0h expected %0h", if8.signature, exp_sig); end
        checks++; if (if8.pass !== (exp_sig == 4'h0)) begin errors++; $display("[TB] FAIL restart_pass got %0b expected %0b", if8.pass, exp_sig == 4'h0); end
        checks++; if (if8.done !== 1'b1) begin errors++; $display("[TB] FAIL restart_done got %0b expected 1", if8.done); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_sig;
        logic [6:0] first_pat;
        int         busy_cyc;
        bit         timed_out;
        for (int r = 0; r < 4; r++) begin
            run_d8(exp_sig, busy_cyc, first_pat, timed_out);
            checks++; if (timed_out) begin errors++; $display("[TB] FAIL b2b_timeout run %0d got busy expected idle", r); end
            checks++; if (if8.signature !== exp_sig) begin errors++; $display("[TB] FAIL b2b_sig run %0d got %0h expected %0h", r, if8.signature, exp_sig); end
            checks++; if (if8.pass !== (exp_sig == 4'h0)) begin errors++; $display("[TB] FAIL b2b_pass run %0d got %0b expected %0b", r, if8.pass, exp_sig == 4'h0); end
            checks++; if (if8.pat_idx !== 8'd8) begin errors++; $display("[TB] FAIL b2b_idx run %0d got %0d expected 8", r, if8.pat_idx); end
        end
    endtask

    task automatic test_midrun_reset();
        resp      = 4'h0;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        for (int m = 0; m < 4; m++) tick();
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("[TB] FAIL ignored_start_busy got %0b expected 1", if8.busy); end
        checks++; if (if8.pat_idx !== 8'd2) begin errors++; $display("[TB] FAIL ignored_start_idx got %0d expected 2", if8.pat_idx); end
        checks++; if (pins8 !== model_pattern(2)) begin errors++; $display("[TB] FAIL ignored_start_pins got %0h expected %0h", pins8, model_pattern(2)); end
        tick();
        checks++; if (if8.pat_idx !== 8'd3) begin errors++; $display("[TB] FAIL continue_idx got %0d expected 3", if8.pat_idx); end
        checks++; if (pins8 !== model_pattern(3)) begin errors++; $display("[TB] FAIL continue_pins got %0h expected %0h", pins8, model_pattern(3)); end
        resp = 4'b1011;
        tick();
        #2 RST = 1'b1;
        #1;
        checks++; if (pins8 !== 7'h00) begin errors++; $display("[TB] FAIL midrst_pins got %0h expected 0", pins8); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %0b expected 0", if8.busy); end
        checks++; if (if8.done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got %0b expected 0", if8.done); end
        checks++; if (if8.signature !== 4'h0) begin errors++; $display("[TB] FAIL midrst_sig got %0h expected 0", if8.signature); end
        checks++; if (if8.pat_idx !== 8'd0) begin errors++; $display("[TB] FAIL midrst_idx got %0d expected 0", if8.pat_idx); end
        checks++; if (if64.done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_other_done got %0b expected 0", if64.done); end
        #1 RST = 1'b0;
    endtask

    initial begin
        spec_seq = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
        if8.start  = 1'b0; if8.abort  = 1'b0;
        if64.start = 1'b0; if64.abort = 1'b0;
        if1.start  = 1'b0; if1.abort  = 1'b0;
        if2.start  = 1'b0; if2.abort  = 1'b0;

        test_reset();
        tick();
        test_lfsr_sequence();
        test_golden();
        test_mismatch();
        test_abort_restart();
        test_back_to_back();
        test_midrun_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s27_bist_ctrl.md
# s27_bist_ctrl

Built-in self-test controller for the s27 combinational core. It generates pseudo-random input patterns with a 7-bit LFSR and drives them onto the core's inputs G0–G7 (G4 is unused). It compacts the core's responses G17, n12, n17 and n22 into a 4-bit MISR and compares the final signature against a golden value. It sits beside the core as the stimulus/response end of the core's pin interface, under control of a start/done handshake.

## Interface
- PAT_COUNT, 64, number of patterns applied per run; legal range 1..255.
- LFSR_SEED, 7'h01, LFSR value loaded at reset and at every start; must be nonzero.
- MISR_SEED, 4'h0, MISR value loaded at reset and at every start.
- GOLDEN_SIG, 4'h0, expected final signature.
- CK  input  1  clock, rising edge.
- RST  input  1  reset; asynchronous, active-high.
- start  input  1  single-cycle request to begin a run.
- abort  input  1  cancels a run in progress.
- G17, n12, n17, n22  input  1 each  responses from the core.
- G0, G1, G2, G3, G5, G6, G7  output  1 each  pattern bits driven to the core.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next start.
- pass  output  1  valid when done=1; high when signature == GOLDEN_SIG.
- signature  output  4  current MISR contents.
- pat_idx  output  8  number of patterns already captured in the current run.

## Operation
- States: IDLE, APPLY, CAPTURE, COMPARE, DONE.
- Pattern mapping: {G7,G6,G5,G3,G2,G1,G0} = lfsr[6:0].
  - Pattern pins are registered.
  - They are driven with lfsr only in APPLY and CAPTURE, and are 0 in all other states.
- LFSR step: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}. This is x^7+x^6+1, period 127. From seed 7'h01 the sequence is 01, 02, 04, 08, 10, 20, 41, 03, ...
- Response vector: resp = {G17, n12, n17, n22}, with resp[3] = G17.
- MISR step: misr <= {misr[2:0], misr[3]^misr[2]} ^ resp. This is x^4+x^3+1.
- IDLE or DONE, start=1:
  - load lfsr=LFSR_SEED, misr=MISR_SEED, pat_idx=0.
  - clear done and pass.
  - go to APPLY.
- APPLY: pattern pins hold lfsr and the core settles. Go to CAPTURE.
- CAPTURE:
  - MISR steps with resp; LFSR steps; pat_idx increments.
  - If the new pat_idx == PAT_COUNT, go to COMPARE; else go to APPLY.
- COMPARE: pass <= (misr == GOLDEN_SIG). Go to DONE.
- DONE: done=1; pass and signature hold. Stay until start, which begins a new run.
- abort=1 in APPLY, CAPTURE or COMPARE:
  - go to IDLE; busy, done and pass are 0.
  - misr and pat_idx hold their values (debug visibility).
  - abort takes priority over start in the same cycle.
- start while busy=1 is ignored.
- busy = 1 exactly in APPLY, CAPTURE and COMPARE.

## Timing
- Reset values: state IDLE, lfsr=LFSR_SEED, misr=MISR_SEED, pat_idx=0, all pattern pins 0, busy=0, done=0, pass=0, signature=MISR_SEED.
- RST asserted mid-run returns everything to these reset values immediately, without waiting for CK.
- start sampled high at edge k:
  - busy=1 and the first pattern is on the pins after edge k.
  - The first capture occurs at edge k+2.
- Each pattern occupies 2 cycles: 1 APPLY, then 1 CAPTURE.
- After the last capture, busy falls and done and pass rise together after edge k+2·PAT_COUNT+1, i.e. one COMPARE cycle after the last capture.
- Total run length: 2·PAT_COUNT+1 cycles of busy.
- Responses are sampled only at the CAPTURE edge. Values on G17/n12/n17/n22 in other states are ignored.
- pat_idx wraps never, because PAT_COUNT ≤ 255.

## Test plan
- Reset:
  - Stimulus: RST pulsed asynchronously, with no CK edge.
  - Response: all pattern pins 0, busy=0, done=0, pass=0, signature=4'h0, pat_idx=0.
- LFSR sequence:
  - Stimulus: PAT_COUNT=8, start for one cycle.
  - Response: pattern pins in successive APPLY cycles read 01, 02, 04, 08, 10, 20, 41, 03.
  - busy lasts 17 cycles; done=1 afterwards.
- Golden match:
  - Stimulus: responses tied to 4'b0000, GOLDEN_SIG=4'h0, PAT_COUNT=64.
  - Response: signature=4'h0, pass=1, done=1, pat_idx=64.
- Mismatch:
  - Stimulus: PAT_COUNT=1, resp={0,0,0,1} during CAPTURE, GOLDEN_SIG=4'h0.
  - Response: signature=4'h1, pass=0, done=1.
  - Stimulus: rerun with PAT_COUNT=2 and the same resp.
  - Response: signature=4'h3.
- Abort and restart:
  - Stimulus: abort at pattern 5; then assert start and abort in the same cycle; then start alone.
  - Response: IDLE with done=0 after the first abort; the simultaneous cycle stays in IDLE; the start-alone run completes normally from pattern 01.
- Mid-run RST and ignored start:
  - Stimulus: start pulsed during APPLY.
  - Response: no restart; pat_idx continues.
  - Stimulus: RST asserted during CAPTURE.
  - Response: immediate return to reset values.
